// File: rtl/std_cache_axi_limiter.sv
// Outstanding-transaction limiter between the cache AXI master port and the interconnect.
// Latency: zero-cycle pass-through on every channel; tracking state updates the cycle after a handshake.
// Backpressure: AR/AW are held back when their class is full or block_i is high; an issued valid is never withdrawn.
// Optional watchdog: define STD_CACHE_AXI_WATCHDOG_EN to build the stuck-traffic timeout.

package std_cache_axi_limiter_pkg;
    typedef struct packed {
        int unsigned AxiIdWidth;
    } cfg_t;

    localparam cfg_t cva6_cfg_empty = '{AxiIdWidth: 4};

    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 64;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
    } ax_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
    } w_t;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [1:0]     resp;
    } b_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
    } r_t;

    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } axi_req_dflt_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        logic b_valid;
        b_t   b;
        logic r_valid;
        r_t   r;
    } axi_rsp_dflt_t;
endpackage

module std_cache_axi_limiter
    import std_cache_axi_limiter_pkg::*;
#(
    parameter cfg_t        CVA6Cfg        = cva6_cfg_empty,
    parameter type         axi_req_t      = std_cache_axi_limiter_pkg::axi_req_dflt_t,
    parameter type         axi_rsp_t      = std_cache_axi_limiter_pkg::axi_rsp_dflt_t,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned WatchdogCycles = 1024
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t slv_req_i,
    output axi_rsp_t slv_resp_o,
    output axi_req_t mst_req_o,
    input  axi_rsp_t mst_resp_i,
    input  logic     block_i,
    output logic     idle_o,
    output logic     err_o,
    output logic     timeout_o
);
    localparam int unsigned IdWidth  = CVA6Cfg.AxiIdWidth;
    localparam logic [3:0]  MAX_CNT  = 4'(MaxOutstanding);
    localparam logic [15:0] WD_LIMIT = 16'(WatchdogCycles - 1);

    // Class 0: I$ (0000), class 1: D$ (0111), class 2: bypass (everything else).
    function automatic logic [1:0] id_class(input logic [IdWidth-1:0] id);
        logic [3:0] low;
        low = id[3:0];
        if (low == 4'b0000)      return 2'd0;
        else if (low == 4'b0111) return 2'd1;
        else                     return 2'd2;
    endfunction

    function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
        if (inc && !dec)                 return cnt + 4'd1;
        else if (dec && !inc && cnt != 0) return cnt - 4'd1;
        else                             return cnt;
    endfunction

    logic [3:0] r_rd_cnt [3];
    logic [3:0] r_wr_cnt [3];
    logic [3:0] w_rd_nxt [3];
    logic [3:0] w_wr_nxt [3];
    logic       r_ar_pend, r_aw_pend, r_err;
    logic [1:0] w_ar_cls, w_aw_cls, w_r_cls, w_b_cls;
    logic       w_ar_allow, w_aw_allow, w_ar_mvld, w_aw_mvld;
    logic       w_ar_hs, w_aw_hs, w_r_done, w_b_done;
    logic       w_uflow, w_all_zero;

    assign w_ar_cls   = id_class(slv_req_i.ar.id);
    assign w_aw_cls   = id_class(slv_req_i.aw.id);
    assign w_r_cls    = id_class(mst_resp_i.r.id);
    assign w_b_cls    = id_class(mst_resp_i.b.id);

    // A pending valid keeps its grant so the handshake can complete even under block_i or a full class.
    assign w_ar_allow = r_ar_pend | (~block_i & (r_rd_cnt[w_ar_cls] != MAX_CNT));
    assign w_aw_allow = r_aw_pend | (~block_i & (r_wr_cnt[w_aw_cls] != MAX_CNT));
    assign w_ar_mvld  = slv_req_i.ar_valid & w_ar_allow;
    assign w_aw_mvld  = slv_req_i.aw_valid & w_aw_allow;
    assign w_ar_hs    = w_ar_mvld & mst_resp_i.ar_ready;
    assign w_aw_hs    = w_aw_mvld & mst_resp_i.aw_ready;
    assign w_r_done   = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    assign w_b_done   = mst_resp_i.b_valid & slv_req_i.b_ready;

    // Pass every channel straight through, gating only the AR/AW handshakes.
    always_comb begin
        mst_req_o             = slv_req_i;
        mst_req_o.ar_valid    = w_ar_mvld;
        mst_req_o.aw_valid    = w_aw_mvld;
        slv_resp_o            = mst_resp_i;
        slv_resp_o.ar_ready   = mst_resp_i.ar_ready & w_ar_allow;
        slv_resp_o.aw_ready   = mst_resp_i.aw_ready & w_aw_allow;
    end

    // Next counter values and underflow detection (a completion for an empty class).
    always_comb begin
        w_uflow    = 1'b0;
        w_all_zero = 1'b1;
        for (int c = 0; c < 3; c++) begin
            w_rd_nxt[c] = cnt_next(r_rd_cnt[c], w_ar_hs && (w_ar_cls == 2'(c)),
                                   w_r_done && (w_r_cls == 2'(c)));
            w_wr_nxt[c] = cnt_next(r_wr_cnt[c], w_aw_hs && (w_aw_cls == 2'(c)),
                                   w_b_done && (w_b_cls == 2'(c)));
            if (w_r_done && (w_r_cls == 2'(c)) && !(w_ar_hs && (w_ar_cls == 2'(c))) && (r_rd_cnt[c] == 4'd0))
                w_uflow = 1'b1;
            if (w_b_done && (w_b_cls == 2'(c)) && !(w_aw_hs && (w_aw_cls == 2'(c))) && (r_wr_cnt[c] == 4'd0))
                w_uflow = 1'b1;
            if ((r_rd_cnt[c] != 4'd0) || (r_wr_cnt[c] != 4'd0))
                w_all_zero = 1'b0;
        end
    end

    // Tracking state: per-class counters, pending-valid flags and the sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < 3; c++) begin
                r_rd_cnt[c] <= 4'd0;
                r_wr_cnt[c] <= 4'd0;
            end
            r_ar_pend <= 1'b0;
            r_aw_pend <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                r_rd_cnt[c] <= w_rd_nxt[c];
                r_wr_cnt[c] <= w_wr_nxt[c];
            end
            r_ar_pend <= w_ar_mvld & ~mst_resp_i.ar_ready;
            r_aw_pend <= w_aw_mvld & ~mst_resp_i.aw_ready;
            if (w_uflow)
                r_err <= 1'b1;
        end
    end

    assign err_o  = r_err;
    assign idle_o = w_all_zero & ~r_ar_pend & ~r_aw_pend & ~slv_req_i.ar_valid & ~slv_req_i.aw_valid;

`ifdef STD_CACHE_AXI_WATCHDOG_EN
    logic [15:0] r_wd;
    logic        r_timeout;

    // Watchdog: count cycles without a completion while anything is outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wd      <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            if (w_r_done || w_b_done || w_all_zero)
                r_wd <= 16'd0;
            else
                r_wd <= r_wd + 16'd1;
            if (r_wd == WD_LIMIT)
                r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unused_wd;
    assign w_unused_wd = ^WD_LIMIT;
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_std_cache_axi_limiter.sv
// Directed bench for std_cache_axi_limiter: a table of per-cycle vectors plus
// hand-written reset, pass-through and watchdog sequences.
module tb_std_cache_axi_limiter;
    import std_cache_axi_limiter_pkg::*;

`ifdef STD_CACHE_AXI_WATCHDOG_EN
    localparam logic WD_EXP = 1'b1;
`else
    localparam logic WD_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    axi_req_dflt_t slv_req;
    axi_rsp_dflt_t slv_resp;
    axi_req_dflt_t mst_req;
    axi_rsp_dflt_t mst_resp;
    logic          blk;
    logic          idle, err, tmo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    std_cache_axi_limiter #(
        .MaxOutstanding (4),
        .WatchdogCycles (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
        .block_i    (blk),
        .idle_o     (idle),
        .err_o      (err),
        .timeout_o  (tmo)
    );

    // exp = {mst ar_valid, slv ar_ready, mst aw_valid, slv aw_ready, idle, err}
    typedef struct {
        logic       blk;
        logic       arv; logic [3:0] arid; logic arr;
        logic       awv; logic [3:0] awid; logic awr;
        logic       rv;  logic [3:0] rid;  logic rl;
        logic       bv;  logic [3:0] bid;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic b, input logic arv, input logic [3:0] arid, input logic arr,
                       input logic awv, input logic [3:0] awid, input logic awr,
                       input logic rv, input logic [3:0] rid, input logic rl,
                       input logic bv, input logic [3:0] bid, input logic [5:0] exp);
        vec_t v;
        v.blk = b; v.arv = arv; v.arid = arid; v.arr = arr;
        v.awv = awv; v.awid = awid; v.awr = awr;
        v.rv = rv; v.rid = rid; v.rl = rl; v.bv = bv; v.bid = bid; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        slv_req = '0;
        slv_req.r_ready = 1'b1;
        slv_req.b_ready = 1'b1;
        mst_resp = '0;
        mst_resp.w_ready = 1'b1;
        blk = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        idle_inputs();
        blk                 = v.blk;
        slv_req.ar_valid    = v.arv;
        slv_req.ar.id       = v.arid;
        mst_resp.ar_ready   = v.arr;
        slv_req.aw_valid    = v.awv;
        slv_req.aw.id       = v.awid;
        slv_req.w_valid     = v.awv;
        slv_req.w.last      = v.awv;
        mst_resp.aw_ready   = v.awr;
        mst_resp.r_valid    = v.rv;
        mst_resp.r.id       = v.rid;
        mst_resp.r.last     = v.rl;
        mst_resp.b_valid    = v.bv;
        mst_resp.b.id       = v.bid;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        // ---------------- vector table ----------------
        add(0,0,0,0, 0,0,0, 0,0,0, 0,0, 6'b000010);          // reset state
        add(0,1,0,1, 1,0,1, 0,0,0, 0,0, 6'b111100);          // I$ AR+AW pass same cycle
        add(0,0,0,0, 0,0,0, 1,0,1, 1,0, 6'b000000);          // completions
        add(0,0,0,0, 0,0,0, 0,0,0, 0,0, 6'b000010);
        for (int i = 0; i < 4; i++)
            add(0,1,7,1, 0,0,0, 0,0,0, 0,0, 6'b110000);      // fill D$ reads
        add(0,1,7,1, 0,0,0, 0,0,0, 0,0, 6'b000000);          // 5th held
        add(0,1,0,1, 0,0,0, 0,0,0, 0,0, 6'b110000);          // I$ independent
        add(0,1,7,1, 0,0,0, 1,7,1, 0,0, 6'b000000);          // completion does not unblock same cycle
        add(0,1,7,1, 0,0,0, 0,0,0, 0,0, 6'b110000);          // issues next cycle
        add(0,0,0,0, 0,0,0, 1,7,0, 0,0, 6'b000000);          // non-last beat
        for (int i = 0; i < 4; i++)
            add(0,0,0,0, 0,0,0, 1,7,1, 0,0, 6'b000000);
        add(0,0,0,0, 0,0,0, 1,0,1, 0,0, 6'b000000);
        add(0,0,0,0, 0,0,0, 0,0,0, 0,0, 6'b000010);
        add(0,1,0,0, 0,0,0, 0,0,0, 0,0, 6'b100000);          // AR valid, not ready
        add(1,1,0,0, 0,0,0, 0,0,0, 0,0, 6'b100000);          // block: valid held
        add(1,1,0,1, 0,0,0, 0,0,0, 0,0, 6'b110000);          // handshake under block
        add(1,1,8,1, 0,0,0, 0,0,0, 0,0, 6'b000000);          // new AR held by block
        add(0,1,8,1, 0,0,0, 0,0,0, 0,0, 6'b110000);
        add(0,0,0,0, 0,0,0, 1,0,1, 0,0, 6'b000000);
        add(0,0,0,0, 0,0,0, 1,8,1, 0,0, 6'b000000);
        add(0,0,0,0, 0,0,0, 0,0,0, 0,0, 6'b000010);
        add(0,1,3,1, 0,0,0, 0,0,0, 0,0, 6'b110000);          // "other" id maps to bypass
        add(0,0,0,0, 0,0,0, 1,8,1, 0,0, 6'b000000);          // bypass completion
        add(0,0,0,0, 0,0,0, 0,0,0, 0,0, 6'b000010);
        add(0,0,0,0, 1,10,0, 0,0,0, 0,0, 6'b001000);         // bypass AW, not ready
        add(1,0,0,0, 1,10,1, 0,0,0, 0,0, 6'b001100);         // pending AW completes under block
        add(0,0,0,0, 0,0,0, 0,0,0, 0,0, 6'b000000);
        add(0,0,0,0, 0,0,0, 0,0,0, 1,10, 6'b000000);
        add(0,0,0,0, 0,0,0, 0,0,0, 0,0, 6'b000010);          // idle the cycle after B
        for (int i = 0; i < 4; i++)
            add(0,0,0,0, 1,7,1, 0,0,0, 0,0, 6'b001100);      // fill D$ writes
        add(0,1,7,1, 1,7,1, 0,0,0, 0,0, 6'b110000);          // AW full, AR unaffected
        add(0,0,0,0, 0,0,0, 1,7,1, 0,0, 6'b000000);
        for (int i = 0; i < 4; i++)
            add(0,0,0,0, 0,0,0, 0,0,0, 1,7, 6'b000000);
        add(0,0,0,0, 0,0,0, 0,0,0, 0,0, 6'b000010);
        add(0,0,0,0, 0,0,0, 0,0,0, 1,7, 6'b000010);          // B on empty class
        add(0,0,0,0, 0,0,0, 0,0,0, 0,0, 6'b000011);          // err set
        add(0,0,0,0, 0,0,0, 1,0,1, 0,0, 6'b000011);          // err sticky

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #3;
            chk($sformatf("vec%0d", i),
                64'({mst_req.ar_valid, slv_resp.ar_ready, mst_req.aw_valid, slv_resp.aw_ready, idle, err}),
                64'(tbl[i].exp));
            next_cycle();
        end

        // ---------------- payload pass-through ----------------
        idle_inputs();
        slv_req.w.data    = 64'hDEAD_BEEF_0123_4567;
        slv_req.w_valid   = 1'b1;
        slv_req.ar.addr   = 32'h8000_1040;
        mst_resp.r.data   = 64'hCAFE_F00D_89AB_CDEF;
        mst_resp.r.resp   = 2'b10;
        #3;
        chk("w_data",  64'(mst_req.w.data), 64'hDEAD_BEEF_0123_4567);
        chk("w_valid", 64'(mst_req.w_valid), 64'd1);
        chk("ar_addr", 64'(mst_req.ar.addr), 64'h8000_1040);
        chk("r_data",  64'(slv_resp.r.data), 64'hCAFE_F00D_89AB_CDEF);
        chk("r_resp",  64'(slv_resp.r.resp), 64'd2);
        chk("w_ready", 64'(slv_resp.w_ready), 64'd1);
        next_cycle();

        // ---------------- reset mid-transaction ----------------
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_err",  64'(err),  64'd0);
        chk("rst_tmo",  64'(tmo),  64'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        slv_req.ar_valid  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        next_cycle();
        idle_inputs();
        #1;
        chk("out_idle", 64'(idle), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_idle", 64'(idle), 64'd1);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        next_cycle();
        idle_inputs();
        #1;
        chk("late_r_err", 64'(err), 64'd1);

        // ---------------- watchdog ----------------
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        slv_req.ar_valid  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        next_cycle();
        idle_inputs();
        repeat (10) next_cycle();
        chk("tmo_early", 64'(tmo), 64'd0);
        repeat (30) next_cycle();
        chk("tmo_late", 64'(tmo), 64'(WD_EXP));
        chk("tmo_err",  64'(err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/std_cache_axi_limiter.md
# std_cache_axi_limiter

Sits directly downstream of the standard cache subsystem's single AXI master port and feeds the SoC interconnect. It classifies each read and write transaction by AXI ID (I$, D$, bypass) and caps the number of outstanding transactions per class and direction. It also holds back new requests on demand and reports when all traffic has drained, for fence and flush handling. All channels pass through with zero latency; only handshake gating and tracking state are added.

## Interface
Parameters:
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`, core configuration; supplies the AXI ID width, which must be ≥4.
- `axi_req_t`, `logic`, AXI request struct type, same as the cache subsystem's.
- `axi_rsp_t`, `logic`, AXI response struct type.
- `MaxOutstanding`, 4, per-class, per-direction limit; range 1..15.
- `WatchdogCycles`, 1024, timeout threshold; used only when the watchdog is compiled in.

Ports:
- `clk_i`  in  1  clock; the block's only clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `slv_req_i`  in  axi_req_t  request from the cache subsystem.
- `slv_resp_o`  out  axi_rsp_t  response to the cache subsystem.
- `mst_req_o`  out  axi_req_t  request to the interconnect.
- `mst_resp_i`  in  axi_rsp_t  response from the interconnect.
- `block_i`  in  1  when high, no new AR or AW is issued.
- `idle_o`  out  1  all counters are zero and no AR or AW valid is pending.
- `err_o`  out  1  sticky; set when a response arrives for a class whose counter is zero.
- `timeout_o`  out  1  sticky watchdog flag.

## Operation
- ID class from the low 4 ID bits:
  - 4'b0000 → I$ (class 0).
  - 4'b0111 → D$ (class 1).
  - 4'b1??? → bypass (class 2).
  - Any other value → bypass.
- Counters: `rd_cnt[3]` and `wr_cnt[3]`, each 4 bits. All reset to 0.
- Read-counter updates:
  - Increment `rd_cnt[c]` on an AR handshake at the master side, with c = class(ar.id).
  - Decrement `rd_cnt[c]` on an R handshake with `r.last`=1, with c = class(r.id).
- Write-counter updates:
  - Increment `wr_cnt[c]` on an AW handshake.
  - Decrement `wr_cnt[c]` on a B handshake.
- Increment and decrement of the same counter in the same cycle → value unchanged.
- Decrement when the counter is 0 → counter stays 0 and `err_o` is set. `err_o` is cleared only by reset.
- AR gating:
  - allow = `ar_pend_q` | (~`block_i` & `rd_cnt[c]` != MaxOutstanding).
  - `mst_req_o.ar_valid` = `slv_req_i.ar_valid` & allow.
  - `slv_resp_o.ar_ready` = `mst_resp_i.ar_ready` & allow.
- AXI valid stability: `ar_pend_q` is set when `mst_req_o.ar_valid` is high and `ar_ready` is low, and cleared on the handshake. Once issued, a valid is never withdrawn, even if `block_i` rises.
- AW uses the same scheme with `aw_pend_q` and `wr_cnt`.
- W, R and B payloads and the W, R, B valid/ready signals pass through unmodified. AR and AW payloads pass through unmodified.
- `idle_o` = all six counters zero & ~`ar_pend_q` & ~`aw_pend_q` & ~`slv_req_i.ar_valid` & ~`slv_req_i.aw_valid`.

## Timing
- Zero-cycle combinational path on every channel. Counter and pending-flag updates are visible in the cycle after the handshake.
- Full boundary: a counter at MaxOutstanding blocks its class on the next request. A completion in the same cycle as a blocked request does not unblock that cycle; the request is issued the following cycle.
- Classes are independent: a full D$ read class does not stall I$ reads.
- Reset values (asynchronous): counters, pending flags, `err_o`, `timeout_o` and the watchdog counter all 0. Therefore `idle_o`=1 when no slave valid is present.
- Reset mid-transaction clears all tracking. Late R/B responses arriving after reset set `err_o`.

## Configuration
- Macro: `STD_CACHE_AXI_WATCHDOG_EN`.
- Defined:
  - A 16-bit watchdog counter clears on any R-last or B handshake, and whenever all counters are zero.
  - Otherwise it increments every cycle.
  - When it reaches WatchdogCycles-1, `timeout_o` is set and stays set until reset.
- Undefined: no watchdog logic is built and `timeout_o` is tied to 0.

## Test plan
- Reset with no traffic → `idle_o`=1, `err_o`=0, `timeout_o`=0; AR/AW with ID 4'b0000 and `ar_ready`=1 pass in the same cycle.
- Issue 4 D$ reads (ID 4'b0111) with no R responses, MaxOutstanding=4 → 5th AR has `mst ar_valid`=0 while I$ reads (ID 4'b0000) still pass. One R with `last`=1 for ID 4'b0111 → 5th AR issues the next cycle.
- AR valid presented with `ar_ready`=0, then `block_i` rises → `mst ar_valid` stays 1 until the handshake. A subsequent AR is held while `block_i`=1.
- Bypass write (ID 4'b1010): AW and W accepted → `idle_o`=0. B response arrives → `idle_o`=1 the next cycle.
- B response with ID 4'b0111 while `wr_cnt[1]`=0 → `err_o`=1 and stays 1; counter remains 0.
- With `STD_CACHE_AXI_WATCHDOG_EN` and WatchdogCycles=16: one AR outstanding with no R → `timeout_o`=1 after 15 cycles. Without the macro → `timeout_o` stays 0.
